// File: rtl/card_pkg.sv
// card_pkg: shared constants, state type and colour palette for the 6x6 card board.
package card_pkg;

    localparam int NUM_CARDS = 36;
    localparam int COLS      = 6;
    localparam int NUM_PAIRS = NUM_CARDS / 2;

    typedef enum logic [1:0] {INIT, SHUFFLE, PLAY} state_t;

    // RGB332 colours, all distinct and nonzero so a read of 0 always means "no card".
    localparam logic [7:0] PALETTE [NUM_PAIRS] = '{
        8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3,
        8'hFF, 8'h92, 8'h49, 8'hA0, 8'h14, 8'h02,
        8'hF0, 8'h8C, 8'h6D, 8'hB6, 8'hDB, 8'h24
    };

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit maximal-length Fibonacci LFSR (taps 8,6,5,4), loadable, steps on demand.
module lfsr8 #(
    parameter logic [7:0] RST_VAL = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst)
            r_q <= RST_VAL;
        else if (load)
            r_q <= seed;
        else if (step)
            r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
    end

    assign q = r_q;

endmodule

// File: rtl/card_board.sv
// card_board: owns card colours and selected/removed vectors; deals a shuffled board,
// serves registered colour reads and applies player picks and match results.
module card_board #(
    parameter int         NUM_CARDS = 36,
    parameter logic [7:0] DEF_SEED  = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           addr,
    output logic [2:0]           r,
    output logic [2:0]           g,
    output logic [1:0]           b,
    output logic [NUM_CARDS-1:0] sel_bus,
    output logic [NUM_CARDS-1:0] hidden_bus,
    input  logic                 ms,
    input  logic                 mf,
    input  logic                 en_input,
    input  logic                 pick,
    input  logic [5:0]           cursor,
    input  logic                 new_game,
    input  logic [7:0]           seed,
    output logic                 busy,
    output logic                 win
);

    import card_pkg::*;

    localparam logic [5:0] LAST = 6'(NUM_CARDS - 1);

    state_t               r_state;
    logic [7:0]           r_col [NUM_CARDS];
    logic [NUM_CARDS-1:0] r_sel;
    logic [NUM_CARDS-1:0] r_hidden;
    logic [5:0]           r_idx;
    logic [7:0]           r_rgb;
    logic [7:0]           r_seed;
    logic [7:0]           w_lfsr;
    logic [5:0]           w_j;
    logic                 w_swap;
    logic                 w_pick_ok;

    lfsr8 #(.RST_VAL(DEF_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (r_state == INIT),
        .seed (r_seed == 8'h00 ? DEF_SEED : r_seed),
        .step (r_state == SHUFFLE),
        .q    (w_lfsr)
    );

    assign w_j       = w_lfsr[5:0];
    assign w_swap    = (r_state == SHUFFLE) && (w_j <= r_idx);
    // With two cards already up, every pick (including a deselect) waits for the matcher.
    assign w_pick_ok = pick && en_input && (cursor <= LAST) && !r_hidden[cursor]
                       && ($countones(r_sel) < 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= INIT;
            r_sel    <= '0;
            r_hidden <= '0;
            r_rgb    <= '0;
            r_seed   <= seed;
            r_idx    <= LAST;
        end else begin
            r_rgb <= (addr <= LAST) ? r_col[addr] : 8'h00;
            if (new_game) begin
                r_state <= INIT;
                r_seed  <= seed;
            end else if (r_state == INIT) begin
                for (int i = 0; i < NUM_CARDS; i++)
                    r_col[i] <= PALETTE[i >> 1];
                r_sel    <= '0;
                r_hidden <= '0;
                r_idx    <= LAST;
                r_state  <= SHUFFLE;
            end else if (r_state == SHUFFLE) begin
                if (w_swap) begin
                    r_col[w_j]   <= r_col[r_idx];
                    r_col[r_idx] <= r_col[w_j];
                    r_idx        <= r_idx - 6'd1;
                    if (r_idx == 6'd1)
                        r_state <= PLAY;
                end
            end else if (ms) begin
                r_hidden <= r_hidden | r_sel;
                r_sel    <= '0;
            end else if (mf) begin
                r_sel <= '0;
            end else if (w_pick_ok) begin
                r_sel[cursor] <= ~r_sel[cursor];
            end
        end
    end

    assign r          = r_rgb[7:5];
    assign g          = r_rgb[4:2];
    assign b          = r_rgb[1:0];
    assign sel_bus    = r_sel;
    assign hidden_bus = r_hidden;
    assign busy       = (r_state != PLAY);
    assign win        = (r_state == PLAY) && (&r_hidden);

endmodule

// File: tb/tb_card_board.sv
// tb_card_board: scoreboard bench for card_board; deal model, pick/match rules, reads, restart.
module tb_card_board;

    localparam int NC = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    addr;
    logic [2:0]    r;
    logic [2:0]    g;
    logic [1:0]    b;
    logic [NC-1:0] sel_bus;
    logic [NC-1:0] hidden_bus;
    logic          ms;
    logic          mf;
    logic          en_input;
    logic          pick;
    logic [5:0]    cursor;
    logic          new_game;
    logic [7:0]    seed;
    logic          busy;
    logic          win;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pal [18] = '{
        8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3,
        8'hFF, 8'h92, 8'h49, 8'hA0, 8'h14, 8'h02,
        8'hF0, 8'h8C, 8'h6D, 8'hB6, 8'hDB, 8'h24
    };
    logic [7:0]    m_col [NC];
    int            m_cyc;
    logic [7:0]    sb [$];
    logic [NC-1:0] exp_sel;
    logic [NC-1:0] exp_hid;

    card_board dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .r          (r),
        .g          (g),
        .b          (b),
        .sel_bus    (sel_bus),
        .hidden_bus (hidden_bus),
        .ms         (ms),
        .mf         (mf),
        .en_input   (en_input),
        .pick       (pick),
        .cursor     (cursor),
        .new_game   (new_game),
        .seed       (seed),
        .busy       (busy),
        .win        (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference deal: Fisher-Yates with rejection driven by the 8-bit Fibonacci LFSR.
    task automatic model(input logic [7:0] s);
        logic [7:0] q;
        logic [7:0] t;
        int idx;
        int j;
        q = (s == 8'h00) ? 8'hA5 : s;
        for (int i = 0; i < NC; i++) m_col[i] = pal[i >> 1];
        idx   = NC - 1;
        m_cyc = 0;
        forever begin
            j = int'(q[5:0]);
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
            m_cyc++;
            if (j <= idx) begin
                t = m_col[j]; m_col[j] = m_col[idx]; m_col[idx] = t;
                if (idx == 1) break;
                idx--;
            end
        end
    endtask

    task automatic wait_play(input string tag, input int exp_n);
        int n = 0;
        do begin
            @(negedge clk);
            new_game = 1'b0;
            n++;
        end while (busy && n < 5000);
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic read_all(input string tag);
        int cnt [18];
        logic [7:0] obs;
        foreach (cnt[p]) cnt[p] = 0;
        for (int a = 0; a <= NC; a++) begin
            if (sb.size() > 0) begin
                obs = {r, g, b};
                chk(tag, 64'(obs), 64'(sb.pop_front()));
                for (int p = 0; p < 18; p++) if (obs == pal[p]) cnt[p]++;
            end
            if (a < NC) begin
                addr = 6'(a);
                sb.push_back(m_col[a]);
            end
            @(negedge clk);
        end
        for (int p = 0; p < 18; p++) chk({tag, "_pair"}, 64'(cnt[p]), 64'd2);
    endtask

    task automatic rd1(input logic [5:0] a, input logic [7:0] e);
        addr = a;
        sb.push_back(e);
        @(negedge clk);
        chk("rd1", 64'({r, g, b}), 64'(sb.pop_front()));
    endtask

    task automatic do_pick(input logic [5:0] c);
        cursor = c;
        pick   = 1'b1;
        @(negedge clk);
        pick   = 1'b0;
    endtask

    task automatic do_ms();
        ms = 1'b1;
        @(negedge clk);
        ms = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; addr = '0; ms = 1'b0; mf = 1'b0; en_input = 1'b1;
        pick = 1'b0; cursor = '0; new_game = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 64'({r, g, b}), 64'd0);
        chk("rst_sel", 64'(sel_bus), 64'd0);
        chk("rst_hid", 64'(hidden_bus), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_win", 64'(win), 64'd0);

        model(8'h00);
        rst = 1'b1;
        wait_play("deal1_cycles", 1 + m_cyc);
        read_all("deal1");

        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_play("deal2_cycles", 1 + m_cyc);
        read_all("deal2");

        exp_sel = '0; exp_hid = '0;
        do_pick(6'd3);
        chk("pick3", 64'(sel_bus), 64'(NC'(1) << 3));
        do_pick(6'd3);
        chk("unpick3", 64'(sel_bus), 64'd0);
        do_pick(6'd3); do_pick(6'd9); do_pick(6'd14);
        exp_sel = (NC'(1) << 3) | (NC'(1) << 9);
        chk("pick_limit", 64'(sel_bus), 64'(exp_sel));
        do_pick(6'd9);
        chk("full_deselect", 64'(sel_bus), 64'(exp_sel));
        do_ms();
        exp_hid = exp_sel;
        chk("ms_hid", 64'(hidden_bus), 64'(exp_hid));
        chk("ms_sel", 64'(sel_bus), 64'd0);
        do_pick(6'd3);
        chk("pick_hidden", 64'(sel_bus), 64'd0);
        do_pick(6'd40);
        chk("pick_range", 64'(sel_bus), 64'd0);
        en_input = 1'b0;
        do_pick(6'd4);
        chk("pick_disabled", 64'(sel_bus), 64'd0);
        en_input = 1'b1;

        do_pick(6'd1); do_pick(6'd2);
        mf = 1'b1;
        @(negedge clk);
        mf = 1'b0;
        chk("mf_sel", 64'(sel_bus), 64'd0);
        chk("mf_hid", 64'(hidden_bus), 64'(exp_hid));

        do_pick(6'd0); do_pick(6'd35);
        ms = 1'b1; mf = 1'b1; pick = 1'b1; cursor = 6'd5;
        @(negedge clk);
        ms = 1'b0; mf = 1'b0; pick = 1'b0;
        exp_hid = exp_hid | NC'(1) | (NC'(1) << 35);
        chk("msmf_hid", 64'(hidden_bus), 64'(exp_hid));
        chk("msmf_sel", 64'(sel_bus), 64'd0);

        rd1(6'd7, m_col[7]);
        rd1(6'd40, 8'h00);
        rd1(6'd35, m_col[35]);

        begin
            int pend = -1;
            for (int i = 0; i < NC; i++) begin
                if (!exp_hid[i]) begin
                    do_pick(6'(i));
                    if (pend < 0) pend = i;
                    else begin
                        chk("win_early", 64'(win), 64'd0);
                        do_ms();
                        exp_hid[pend] = 1'b1;
                        exp_hid[i]    = 1'b1;
                        pend = -1;
                    end
                end
            end
        end
        chk("all_hid", 64'(hidden_bus), 64'(exp_hid));
        chk("win", 64'(win), 64'd1);

        seed = 8'h3C;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_hid", 64'(hidden_bus), 64'd0);
        chk("mid_sel", 64'(sel_bus), 64'd0);
        chk("mid_win", 64'(win), 64'd0);
        model(8'h77);
        seed = 8'h77;
        new_game = 1'b1;
        wait_play("regame_cycles", 2 + m_cyc);
        chk("regame_win", 64'(win), 64'd0);
        chk("regame_hid", 64'(hidden_bus), 64'd0);
        read_all("deal3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
